// File: rtl/xg_axis_downsizer.sv
// Wide-to-narrow AXI4-Stream converter (R = S/M slices per beat); 1-cycle latency; trims empty trailing slices of last beat.
// Backpressure: s_axis_tready is combinational, high when the buffer is empty or its final slice is being consumed.
module xg_axis_downsizer #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_TUSER_ALL_BEATS    = 0
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [31:0]                       pkt_count,
  output logic                              keep_err
);

  localparam int S  = C_S_AXIS_DATA_WIDTH;
  localparam int M  = C_M_AXIS_DATA_WIDTH;
  localparam int R  = S / M;
  localparam int KS = S / 8;
  localparam int KM = M / 8;
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  logic [S-1:0]                    r_data;
  logic [KS-1:0]                   r_keep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] r_user;
  logic                            r_last;
  logic                            r_vld;
  logic [IW-1:0]                   r_idx;
  logic                            r_first;
  logic [31:0]                     r_pkt_count;
  logic                            r_keep_err;

  logic [M-1:0]  w_slice_dat;
  logic [KM-1:0] w_slice_keep;
  logic          w_upper_zero;
  logic          w_final;
  logic          w_noncontig;
  logic          w_keep_bad;
  logic          w_out_hs;
  logic          w_in_hs;

  // Slice mux and "nothing left above the current slice" detection
  always_comb begin
    w_slice_dat  = '0;
    w_slice_keep = '0;
    w_upper_zero = 1'b1;
    for (int k = 0; k < R; k++) begin
      if (IW'(k) == r_idx) begin
        w_slice_dat  = r_data[k*M +: M];
        w_slice_keep = r_keep[k*KM +: KM];
      end
      if ((IW'(k) > r_idx) && (|r_keep[k*KM +: KM])) w_upper_zero = 1'b0;
    end
  end

  always_comb begin
    w_noncontig = 1'b0;
    for (int i = 1; i < KS; i++) begin
      if (s_axis_tkeep[i] && !s_axis_tkeep[i-1]) w_noncontig = 1'b1;
    end
  end

  assign w_final    = (r_idx == IW'(R-1)) || (r_last && w_upper_zero);
  assign w_keep_bad = (!s_axis_tlast && !(&s_axis_tkeep)) || w_noncontig;
  assign w_out_hs   = r_vld && m_axis_tready;
  assign w_in_hs    = s_axis_tvalid && s_axis_tready;

  assign s_axis_tready = !r_vld || (m_axis_tready && w_final);
  assign m_axis_tvalid = r_vld;
  assign m_axis_tdata  = w_slice_dat;
  assign m_axis_tkeep  = w_slice_keep;
  assign m_axis_tlast  = r_last && w_final;
  assign m_axis_tuser  = (C_TUSER_ALL_BEATS != 0 || r_first) ? r_user : '0;
  assign pkt_count     = r_pkt_count;
  assign keep_err      = r_keep_err;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_data      <= '0;
      r_keep      <= '0;
      r_user      <= '0;
      r_last      <= 1'b0;
      r_vld       <= 1'b0;
      r_idx       <= '0;
      r_first     <= 1'b1;
      r_pkt_count <= '0;
      r_keep_err  <= 1'b0;
    end else begin
      // An input load always coincides with (or replaces) the final-slice consume
      if (w_in_hs) begin
        r_data <= s_axis_tdata;
        r_keep <= s_axis_tkeep;
        r_user <= s_axis_tuser;
        r_last <= s_axis_tlast;
        r_vld  <= 1'b1;
        r_idx  <= '0;
      end else if (w_out_hs && w_final) begin
        r_vld <= 1'b0;
        r_idx <= '0;
      end else if (w_out_hs) begin
        r_idx <= r_idx + IW'(1);
      end
      if (w_out_hs) begin
        r_first <= m_axis_tlast;
        if (m_axis_tlast) r_pkt_count <= r_pkt_count + 32'd1;
      end
      if (w_in_hs && w_keep_bad) r_keep_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xg_axis_downsizer.sv
// Randomised bench for xg_axis_downsizer (256->64, TUSER mode 0) against a queue-based slice model.
module tb_xg_axis_downsizer;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [255:0]  s_tdata = '0;
  logic [31:0]   s_tkeep = '0;
  logic [127:0]  s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic [127:0]  m_tuser;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [31:0]   pkt_count;
  logic          keep_err;

  xg_axis_downsizer dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .pkt_count(pkt_count), .keep_err(keep_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  d;
    logic [7:0]   k;
    logic [127:0] u;
    logic         l;
    logic         eow;
  } exp_t;

  exp_t         q[$];
  logic [63:0]  log_d[$];
  logic [7:0]   log_k[$];
  logic [127:0] log_u[$];
  logic         log_l[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           rdy_mode = 0;
  logic [31:0]  exp_pkts = '0;
  logic         exp_err = 1'b0;
  logic         m_first = 1'b1;

  localparam logic [255:0] D1 = {64'h4444444444444444, 64'h3333333333333333,
                                 64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] D2 = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                                 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
  localparam logic [127:0] U1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] U2 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] U4 = 128'hCAFEF00D_0000_0000_0000_0000_DEADBEEF;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expand one accepted wide beat into the narrow beats it must produce
  task automatic model_push(input logic [255:0] d, input logic [31:0] k,
                            input logic [127:0] u, input logic l);
    int hb = -1;
    int n;
    int pc;
    logic [31:0] mask = '0;
    exp_t e;
    for (int b = 0; b < 32; b++) if (k[b]) hb = b;
    n = !l ? 4 : (hb < 0 ? 1 : hb / 8 + 1);
    for (int s = 0; s < n; s++) begin
      e.d   = d[s*64 +: 64];
      e.k   = k[s*8 +: 8];
      e.u   = m_first ? u : '0;
      e.l   = l && (s == n - 1);
      e.eow = (s == n - 1);
      m_first = e.l;
      q.push_back(e);
    end
    pc = $countones(k);
    for (int i = 0; i < pc; i++) mask[i] = 1'b1;
    if ((!l && k != 32'hFFFFFFFF) || (k != mask)) exp_err = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: every negedge, DUT state against model
  initial begin
    logic exp_srdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        exp_pkts = '0;
        exp_err  = 1'b0;
        m_first  = 1'b1;
        chk("tvalid_in_reset", 256'(m_tvalid), 256'(0));
      end else begin
        exp_srdy = (q.size() == 0) ? 1'b1 : (m_tready && q[0].eow);
        chk("m_tvalid", 256'(m_tvalid), 256'(q.size() != 0));
        chk("s_tready", 256'(s_tready), 256'(exp_srdy));
        chk("pkt_count", 256'(pkt_count), 256'(exp_pkts));
        chk("keep_err", 256'(keep_err), 256'(exp_err));
        if (m_tvalid && q.size() > 0) begin
          chk("m_tdata", 256'(m_tdata), 256'(q[0].d));
          chk("m_tkeep", 256'(m_tkeep), 256'(q[0].k));
          chk("m_tuser", 256'(m_tuser), 256'(q[0].u));
          chk("m_tlast", 256'(m_tlast), 256'(q[0].l));
          if (m_tready) begin
            if (q[0].l) exp_pkts = exp_pkts + 32'd1;
            log_d.push_back(m_tdata);
            log_k.push_back(m_tkeep);
            log_u.push_back(m_tuser);
            log_l.push_back(m_tlast);
            void'(q.pop_front());
          end
        end
        if (s_tvalid && s_tready) model_push(s_tdata, s_tkeep, s_tuser, s_tlast);
      end
    end
  end

  task automatic clear_log();
    log_d.delete(); log_k.delete(); log_u.delete(); log_l.delete();
  endtask

  // Entered and left at posedge+1; leaves s_tvalid high for back-to-back beats
  task automatic send(input logic [255:0] d, input logic [31:0] k,
                      input logic [127:0] u, input logic l);
    int cnt = 0;
    s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    do begin
      @(negedge clk);
      cnt++;
    end while (!s_tready && cnt < 200);
    if (!s_tready) chk("send_timeout", 256'(0), 256'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cnt = 0;
    s_tvalid = 1'b0;
    do begin
      @(negedge clk);
      #1;
      cnt++;
    end while (q.size() != 0 && cnt < 300);
    if (q.size() != 0) chk("drain_timeout", 256'(q.size()), 256'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic rand_pkt();
    int nb = $urandom_range(1, 4);
    int vb;
    logic [127:0] u;
    for (int b = 0; b < nb; b++) begin
      u = {$urandom, $urandom, $urandom, $urandom};
      if (b < nb - 1) send(rnd256(), 32'hFFFFFFFF, u, 1'b0);
      else begin
        vb = $urandom_range(0, 32);
        send(rnd256(), (vb == 0) ? 32'h0 : (32'hFFFFFFFF >> (32 - vb)), u, 1'b1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 256'(m_tvalid), 256'(0));
    chk("rst_tdata", 256'(m_tdata), 256'(0));
    chk("rst_tkeep", 256'(m_tkeep), 256'(0));
    chk("rst_tuser", 256'(m_tuser), 256'(0));
    chk("rst_tlast", 256'(m_tlast), 256'(0));
    chk("rst_tready", 256'(s_tready), 256'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single full packet
    clear_log();
    send(D1, 32'hFFFFFFFF, U1, 1'b1);
    drain();
    chk("t1_nbeats", 256'(log_d.size()), 256'(4));
    if (log_d.size() == 4) begin
      chk("t1_d0", 256'(log_d[0]), 256'(64'h1111111111111111));
      chk("t1_d3", 256'(log_d[3]), 256'(64'h4444444444444444));
      chk("t1_l2", 256'(log_l[2]), 256'(0));
      chk("t1_l3", 256'(log_l[3]), 256'(1));
      chk("t1_u0", 256'(log_u[0]), 256'(U1));
    end
    chk("t1_pkts", 256'(pkt_count), 256'(1));

    // Short last beat
    clear_log();
    send(D1, 32'hFFFFFFFF, U2, 1'b0);
    send(D2, 32'h000000FF, U1, 1'b1);
    drain();
    chk("t2_nbeats", 256'(log_d.size()), 256'(5));
    if (log_d.size() == 5) begin
      chk("t2_k4", 256'(log_k[4]), 256'(8'hFF));
      chk("t2_l4", 256'(log_l[4]), 256'(1));
      chk("t2_d4", 256'(log_d[4]), 256'(64'hAAAAAAAAAAAAAAAA));
      chk("t2_u0", 256'(log_u[0]), 256'(U2));
      chk("t2_u4", 256'(log_u[4]), 256'(0));
    end

    // Backpressure with alternating ready
    clear_log();
    rdy_mode = 1;
    send(rnd256(), 32'hFFFFFFFF, U1, 1'b0);
    send(rnd256(), 32'hFFFFFFFF, U2, 1'b0);
    send(rnd256(), 32'hFFFFFFFF, U4, 1'b1);
    drain();
    rdy_mode = 0;
    chk("t3_nbeats", 256'(log_d.size()), 256'(12));
    chk("t3_pkts", 256'(pkt_count), 256'(3));
    chk("t3_err", 256'(keep_err), 256'(0));

    // Keep error on non-last beat, then empty tlast beat
    clear_log();
    send(D1, 32'h0FFFFFFF, U1, 1'b0);
    send(D2, 32'h0, U2, 1'b1);
    drain();
    chk("t4_err", 256'(keep_err), 256'(1));
    chk("t4_nbeats", 256'(log_d.size()), 256'(5));
    if (log_d.size() == 5) begin
      chk("t4_k3", 256'(log_k[3]), 256'(8'h0F));
      chk("t4_k4", 256'(log_k[4]), 256'(0));
      chk("t4_l4", 256'(log_l[4]), 256'(1));
    end

    // Random back-to-back packets
    for (int p = 0; p < 100; p++) rand_pkt();
    drain();
    chk("t5_pkts", 256'(pkt_count), 256'(104));
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) rand_pkt();
    drain();
    rdy_mode = 0;
    chk("t5b_pkts", 256'(pkt_count), 256'(144));

    // Reset in the middle of a wide beat
    clear_log();
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    send(D1, 32'hFFFFFFFF, U1, 1'b0);
    s_tvalid = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      #1;
      cnt++;
    end while (log_d.size() < 2 && cnt < 50);
    chk("t6_slices_before_rst", 256'(log_d.size()), 256'(2));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_tvalid_rst", 256'(m_tvalid), 256'(0));
    chk("t6_pkts_rst", 256'(pkt_count), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_err_rst", 256'(keep_err), 256'(0));
    clear_log();
    send(D2, 32'hFFFFFFFF, U4, 1'b1);
    drain();
    chk("t6_nbeats", 256'(log_d.size()), 256'(4));
    if (log_d.size() == 4) begin
      chk("t6_u0", 256'(log_u[0]), 256'(U4));
      chk("t6_d0", 256'(log_d[0]), 256'(64'hAAAAAAAAAAAAAAAA));
    end
    chk("t6_pkts", 256'(pkt_count), 256'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xg_axis_downsizer.md
# xg_axis_downsizer

Parametrised wide-to-narrow AXI4-Stream width converter for the 10G TX datapath. It accepts wide beats from the user datapath, default 256 bits, and emits them as narrow beats, default 64 bits, toward the 10G MAC transmit interface. Unlike the fixed-ratio converter currently in place, it supports any power-of-two ratio, trims empty trailing slices of the last beat, places TUSER according to a selectable mode, and reports status counters. It sits in the `axi_aclk` domain, between the user TX stream and the MAC TX stream.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, 256: input data width; must be a multiple of 8.
- `C_M_AXIS_DATA_WIDTH`, 64: output data width; R = S/M must be 1, 2, 4 or 8.
- `C_S_AXIS_TUSER_WIDTH`, 128: input TUSER width.
- `C_M_AXIS_TUSER_WIDTH`, 128: output TUSER width; must equal the input width.
- `C_TUSER_ALL_BEATS`, 0: TUSER mode. 0 = TUSER on the first narrow beat of each packet, zeros elsewhere. 1 = every narrow beat of a wide beat repeats that wide beat's TUSER.

Ports:
- `axi_aclk` in 1: the only clock.
- `axi_resetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in S: input data.
- `s_axis_tkeep` in S/8: input byte enables.
- `s_axis_tuser` in TU: input user data.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tlast` in 1: input end of packet.
- `s_axis_tready` out 1: input ready.
- `m_axis_tdata` out M: output data.
- `m_axis_tkeep` out M/8: output byte enables.
- `m_axis_tuser` out TU: output user data.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tlast` out 1: output end of packet.
- `m_axis_tready` in 1: output ready.
- `pkt_count` out 32: number of packets emitted; wraps.
- `keep_err` out 1: sticky TKEEP error flag.

## Operation
- Holding register: one wide beat (`data`, `keep`, `user`, `last`), plus `buf_valid`, slice index `idx` (log2 R bits) and a `first_of_pkt` flag.
- Slice k is `data[k*M +: M]` with `keep[k*M/8 +: M/8]`. Slice 0 is emitted first (little-endian lane order).
- The current slice is the final slice of the buffered beat when either:
  - `idx == R-1`, or
  - `last` is 1 and every keep bit above slice `idx` is 0.
- `m_axis_tlast = last && final slice`.
- A tlast beat with all keep bits zero emits exactly one slice: slice 0, tkeep 0, tlast 1.
- Non-last beats always emit all R slices, regardless of keep.
- Outputs: `m_axis_tvalid = buf_valid`. `m_axis_tdata`/`tkeep` are the current slice. `m_axis_tuser`:
  - mode 0: `user` when `first_of_pkt`, else 0;
  - mode 1: always `user`.
- Output handshake (`m_axis_tvalid && m_axis_tready`):
  - not on the final slice: `idx++`;
  - on the final slice: `idx <= 0`, and `buf_valid` clears unless a new beat is loaded in the same cycle.
- `first_of_pkt` is set at reset and after any emitted tlast beat. It clears after any other emitted beat.
- `s_axis_tready = !buf_valid || (m_axis_tready && final slice)`. This is combinational and gives back-to-back wide beats with no bubble.
- On input accept, load the buffer and set `buf_valid = 1`.
- `keep_err` sets on an accepted beat when either:
  - `tlast == 0` and tkeep is not all ones, or
  - tkeep is non-contiguous (a 1 above a 0).

  It clears only on reset. The data is still forwarded.
- `pkt_count` increments on each emitted tlast narrow beat and wraps from 0xFFFFFFFF to 0.
- R = 1: behaves as a single-stage register slice with the same handshake rules.

## Timing
- Reset values (asynchronous, while `axi_resetn` = 0):
  - `m_axis_tvalid` = 0;
  - `m_axis_tdata`/`tkeep`/`tuser`/`tlast` = 0;
  - `pkt_count` = 0, `keep_err` = 0;
  - `idx` = 0, `first_of_pkt` = 1;
  - `s_axis_tready` = 1 once the buffer is empty.
- Reset asserted mid-packet: the buffered beat is discarded with no partial tlast emitted. The next accepted beat is treated as the first beat of a packet.
- Latency: an input accepted at edge n gives `m_axis_tvalid` = 1 after edge n (one cycle).
- Throughput: a full beat takes R cycles. A trimmed last beat takes ceil(valid bytes / (M/8)) cycles, minimum 1.
- Handshake rules:
  - Output fields stay stable while `m_axis_tvalid && !m_axis_tready`.
  - `m_axis_tvalid` never drops without a handshake.
- Simultaneous final-slice consume and input load in one cycle: the new beat replaces the old, `idx` = 0, and `buf_valid` stays 1.

## Test plan
- **Single full packet, R = 4:** one 256-bit beat, keep all ones, tlast = 1, `m_axis_tready` held 1 → four 64-bit beats on cycles 1–4. Only the 4th has tlast. `pkt_count` = 1.
- **Short last beat:** 2-beat packet, second beat keep = 0x000000FF → 4 + 1 narrow beats. The last has tkeep 0xFF and tlast. Mode 0: TUSER is nonzero only on narrow beat 0.
- **Backpressure:** toggle `m_axis_tready` 1010… during a 3-beat packet → narrow data in order with no loss or duplication. `s_axis_tready` stays low until the final slice of each beat is consumed.
- **Back-to-back packets:** 100 packets of random length with `m_axis_tready` = 1 → no bubble between wide beats. `pkt_count` = 100. The scoreboard matches byte-for-byte.
- **Errors and empty beat:** non-last beat with keep 0x0FFFFFFF → `keep_err` = 1 and all 4 slices emitted. A tlast beat with keep 0 → one beat, tkeep 0, tlast 1.
- **Reset mid-packet:** assert `axi_resetn` = 0 after slice 1 of a full beat → `m_axis_tvalid` = 0 immediately. After release, a new packet carries TUSER on its first narrow beat.
